// File: rtl/num_sink.sv
// num_sink: NoC endpoint that checks a num_gen operand stream.
// It regenerates the sender's LFSR sequence locally, compares every beat,
// counts data and framing errors, then returns one status packet.
// Status word: [15:0] beats, [30:16] errors, [31] timeout flag.
// Optional idle timeout is enabled with `define NUM_SINK_TIMEOUT_EN.
module num_sink #(
    parameter int                 TDATAW         = 32,
    parameter int                 TDESTW         = 4,
    parameter int                 LFSR_DW        = 8,
    parameter logic [LFSR_DW-1:0] LFSR_DEFAULT   = 8'h01,
    parameter int                 NUM_PACKETS    = 16,
    parameter int                 REPORT_DEST    = 0,
    parameter int                 TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    output logic              DONE,
    output logic [14:0]       ERR_COUNT,
    output logic [TDATAW-1:0] LAST_DATA_O,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST
);

    typedef enum logic [1:0] {IDLE, RECV, REPORT, DONE_ST} state_t;

    state_t              state_reg,     state_next;
    logic [15:0]         beat_cnt_reg,  beat_cnt_next;
    logic [14:0]         err_cnt_reg,   err_cnt_next;
    logic [LFSR_DW-1:0]  lfsr_reg,      lfsr_next;
    logic [TDATAW-1:0]   last_data_reg, last_data_next;
    logic                s_tready_reg,  s_tready_next;
    logic                m_tvalid_reg,  m_tvalid_next;
    logic [TDATAW-1:0]   m_tdata_reg,   m_tdata_next;
    logic                m_tlast_reg,   m_tlast_next;
    logic [TDESTW-1:0]   m_tdest_reg,   m_tdest_next;
    logic                done_reg,      done_next;
    logic                timeout_reg,   timeout_next;

    logic                beat;
    logic                final_beat;
    logic                timeout_hit;
    logic                enter_report;
    logic                beat_bad;

    // Slave-side destination carries no meaning for this endpoint.
    logic                s_tdest_unused;
    assign s_tdest_unused = ^AXIS_S_TDEST;

    assign beat       = AXIS_S_TVALID && s_tready_reg && (state_reg == RECV);
    assign final_beat = beat && (beat_cnt_reg == 16'(NUM_PACKETS - 1));
    assign beat_bad   = (AXIS_S_TDATA != TDATAW'(lfsr_reg)) || (AXIS_S_TLAST != final_beat);

`ifdef NUM_SINK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;

    // Idle cycles counted only while waiting for beats in RECV.
    always_comb begin
        idle_cnt_next = '0;
        timeout_hit   = 1'b0;
        if (state_reg == RECV && !beat) begin
            if (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                idle_cnt_next = idle_cnt_reg + 1'b1;
            end
        end
    end

    // Idle counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) idle_cnt_reg <= '0;
        else        idle_cnt_reg <= idle_cnt_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state, counters, checker and status packet formation.
    always_comb begin
        state_next     = state_reg;
        beat_cnt_next  = beat_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        lfsr_next      = lfsr_reg;
        last_data_next = last_data_reg;
        s_tready_next  = s_tready_reg;
        m_tvalid_next  = m_tvalid_reg;
        m_tdata_next   = m_tdata_reg;
        m_tlast_next   = m_tlast_reg;
        m_tdest_next   = m_tdest_reg;
        done_next      = done_reg;
        timeout_next   = timeout_reg;
        enter_report   = 1'b0;

        case (state_reg)
            IDLE, DONE_ST: begin
                s_tready_next = 1'b0;
                if (START) begin
                    beat_cnt_next = '0;
                    err_cnt_next  = '0;
                    lfsr_next     = LFSR_DEFAULT;
                    timeout_next  = 1'b0;
                    done_next     = 1'b0;
                    state_next    = RECV;
                end
            end
            RECV: begin
                s_tready_next = 1'b1;
                if (beat) begin
                    last_data_next = AXIS_S_TDATA;
                    beat_cnt_next  = beat_cnt_reg + 1'b1;
                    lfsr_next      = {lfsr_reg[LFSR_DW-2:0],
                                      lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
                    if (beat_bad && err_cnt_reg != 15'h7FFF) begin
                        err_cnt_next = err_cnt_reg + 1'b1;
                    end
                end
                if (final_beat) begin
                    enter_report = 1'b1;
                end else if (timeout_hit) begin
                    timeout_next = 1'b1;
                    enter_report = 1'b1;
                end
            end
            REPORT: begin
                if (AXIS_M_TREADY) begin
                    m_tvalid_next = 1'b0;
                    m_tlast_next  = 1'b0;
                    done_next     = 1'b1;
                    state_next    = DONE_ST;
                end
            end
            default: state_next = IDLE;
        endcase

        // Status word is captured once so it stays stable under backpressure.
        if (enter_report) begin
            s_tready_next        = 1'b0;
            state_next           = REPORT;
            m_tvalid_next        = 1'b1;
            m_tlast_next         = 1'b1;
            m_tdest_next         = TDESTW'(REPORT_DEST);
            m_tdata_next         = '0;
            m_tdata_next[15:0]   = beat_cnt_next;
            m_tdata_next[30:16]  = err_cnt_next;
            m_tdata_next[31]     = timeout_next;
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            err_cnt_reg   <= '0;
            lfsr_reg      <= LFSR_DEFAULT;
            last_data_reg <= '0;
            s_tready_reg  <= 1'b0;
            m_tvalid_reg  <= 1'b0;
            m_tdata_reg   <= '0;
            m_tlast_reg   <= 1'b0;
            m_tdest_reg   <= '0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            lfsr_reg      <= lfsr_next;
            last_data_reg <= last_data_next;
            s_tready_reg  <= s_tready_next;
            m_tvalid_reg  <= m_tvalid_next;
            m_tdata_reg   <= m_tdata_next;
            m_tlast_reg   <= m_tlast_next;
            m_tdest_reg   <= m_tdest_next;
            done_reg      <= done_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign DONE          = done_reg;
    assign ERR_COUNT     = err_cnt_reg;
    assign LAST_DATA_O   = last_data_reg;
    assign AXIS_S_TREADY = s_tready_reg;
    assign AXIS_M_TVALID = m_tvalid_reg;
    assign AXIS_M_TDATA  = m_tdata_reg;
    assign AXIS_M_TLAST  = m_tlast_reg;
    assign AXIS_M_TDEST  = m_tdest_reg;

endmodule
